fmul_rr_sched: RTL
==================

# fmul_rr_sched

Round-robin scheduler that shares one pipelined FloPoCo 11-bit float multiplier (wE=4, wF=4) between `NUM_REQ` requesters. It accepts at most one operand pair per cycle with a valid/ready handshake, drives the multiplier's X/Y from registers, and carries a requester tag down a shift register matched to the multiplier latency. It returns each product on a shared result bus tagged with the requester ID. It sits between datapath lanes and a single `fmul` instance, which stays outside this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FP_W`, 11: float width (2 exception + 1 sign + 4 exponent + 4 fraction).
- `MUL_LAT`, 2: clock edges from `mul_x`/`mul_y` changing to the matching `mul_r` being valid.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: requester k has an operand pair.
- `req_x`, `req_y`  in  NUM_REQ*FP_W: packed operands; lane k is bits [k*FP_W +: FP_W].
- `req_ready`  out  NUM_REQ: one-hot grant, combinational.
- `hold`  in  1: suppress new grants (drain mode).
- `mul_x`, `mul_y`  out  FP_W: registered multiplier operands.
- `mul_r`  in  FP_W: multiplier product.
- `res_valid`  out  1: product valid this cycle.
- `res_id`  out  $clog2(NUM_REQ): requester that owns `res_data`.
- `res_data`  out  FP_W: product.
- `busy`  out  1: at least one operation is in flight.

## Operation
- **Arbitration:** `req_ready[k]=1` for the first k with `req_valid[k]`, searching from `rr_ptr` upward with wrap. `req_ready` is all zero when `hold` is 1, during reset, or when no request is present.
- **Ready/valid independence:** `req_ready` never depends on `req_valid[k]` of the granted lane alone, and requesters must not wait for ready before asserting valid.
- **Accept:** on `req_valid[k] && req_ready[k]` at an edge:
  - `mul_x <= req_x[k]` and `mul_y <= req_y[k]`.
  - The tag pipe stage 0 loads {valid=1, id=k}.
  - `rr_ptr <= (k+1) mod NUM_REQ`.
- **Idle inputs:** with no accept, `mul_x`/`mul_y` hold their value and tag stage 0 loads valid=0. `rr_ptr` is unchanged.
- **Tag pipe:** `MUL_LAT+1` stages, shifting every cycle. There is no stall because the multiplier has no clock enable.
- **Result register:** updates every edge from the last tag stage:
  - `res_valid` takes the last stage's valid bit.
  - `res_id` takes the last stage's id.
  - `res_data` takes `mul_r`.
- **Data is not masked:** `res_data` is unconditionally registered and is meaningful only when `res_valid` is 1.
- **In-flight counter:** width $clog2(MUL_LAT+3). It increments on accept, decrements on `res_valid`, and does both (net 0) when both happen in the same cycle. `busy` = counter != 0.
- **No result backpressure:** consumers must sink `res_*` in the cycle it is valid.
- **hold:** stops new accepts only. In-flight results still drain, and `busy` falls after the last one.
- **Reset:**
  - `rr_ptr=0`, all tag valid bits 0, counter 0.
  - `mul_x=mul_y=0`.
  - `res_valid=0`, `res_id=0`, `res_data=0`.
- **Reset mid-operation:** all in-flight operations are dropped and no `res_valid` is produced for them. Whatever the multiplier still holds is ignored because the tags are cleared.

## Timing
- **Accept at edge t:** `mul_x`/`mul_y` are visible after edge t and `mul_r` is valid after edge t+MUL_LAT.
- **Result:** `res_valid` is high for exactly one cycle, after edge t+MUL_LAT+1. Accept-to-result latency is MUL_LAT+1 edges, which is 3 with the defaults.
- **Throughput:** one accept per cycle. Results come back in accept order with no gaps introduced.
- **Single active requester:** it is granted every cycle. `rr_ptr` wraps back to the same k after NUM_REQ-1 increments are skipped.
- **Pointer wrap:** with `rr_ptr=NUM_REQ-1` and requests at lanes 0 and NUM_REQ-1, lane NUM_REQ-1 wins and `rr_ptr` becomes 0.
- **Simultaneous accept and result:** the counter is unchanged and `busy` stays 1.

## Structure
- **Package `fmul_sched_pkg`:**
  - `FP_W`.
  - Exception encodings: 00 zero, 01 normal, 10 inf, 11 NaN.
  - Constants `FP_ONE=01001110000`, `FP_TWO=01010000000`.
  - Typedef `tag_t` {valid, id}.
- **Sub-module `rr_arbiter`:** `NUM_REQ`-wide, with request vector, pointer and enable in, and one-hot grant plus encoded index out. Combinational, reused elsewhere.
- **Top level:** tag shift register, operand registers, counter, result register.

## Test plan
- **Single op:** reset, then lane 0 presents X=01010000000 (2.0), Y=01010001000 (3.0) → accepted next edge; `res_valid` for one cycle 3 edges later with `res_id=0`, `res_data=01010011000` (6.0); `busy` goes 1 then 0.
- **Fairness:** all 4 lanes valid continuously → grants 0,1,2,3,0,… one per cycle; results arrive with ids 0,1,2,3 in order, 3 cycles behind each grant.
- **Back-to-back products:** lane 2 sends 1.5×2.0 (01001111000×01010000000) then 2.0×2.0 on consecutive cycles → results 01010001000 then 01010010000 on consecutive cycles, `res_id=2`.
- **hold:** assert `hold` with 2 ops in flight → `req_ready=0`, both results still delivered, `busy` drops after the second one.
- **Mid-flight reset:** `reset` pulsed one cycle after an accept → no `res_valid` for that op, all outputs 0, `rr_ptr=0`, so the next grant goes to the lowest valid lane.
- **Pointer wrap:** only lanes 3 and 0 requesting, starting from `rr_ptr=3` → grants 3,0,3,0.

Source files
------------

// File: rtl/fmul_sched_pkg.sv
// Shared types and constants for the round-robin fmul scheduler.
// Floats are FloPoCo-style: {exception[1:0], sign, exponent[3:0], fraction[3:0]}.
package fmul_sched_pkg;

  localparam int unsigned FP_W     = 11;
  localparam int unsigned TAG_ID_W = 3;  // enough for up to 8 requesters

  typedef enum logic [1:0] {
    ExcZero   = 2'b00,
    ExcNormal = 2'b01,
    ExcInf    = 2'b10,
    ExcNan    = 2'b11
  } exc_e;

  localparam logic [FP_W-1:0] FP_ONE = 11'b01001110000;
  localparam logic [FP_W-1:0] FP_TWO = 11'b01010000000;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fmul_rr_sched_if.sv
// Requester-side bus of the scheduler: operand handshake, drain control and tagged results.
interface fmul_rr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FP_W    = fmul_sched_pkg::FP_W
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*FP_W-1:0] req_x;
  logic [NUM_REQ*FP_W-1:0] req_y;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    hold;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [FP_W-1:0]         res_data;
  logic                    busy;

  modport master (
    output req_valid, req_x, req_y, hold,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, hold,
    output req_ready, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i (with wrap) wins.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  always_comb begin
    int unsigned k;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (en_i && !found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/fmul_rr_sched.sv
// Shares one pipelined float multiplier between NUM_REQ requesters; a tag pipe matched to
// the multiplier latency routes each product back to its requester on a shared result bus.
module fmul_rr_sched
  import fmul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FP_W    = fmul_sched_pkg::FP_W,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  fmul_rr_sched_if.slave  bus_io,
  output logic [FP_W-1:0] mul_x_o,
  output logic [FP_W-1:0] mul_y_o,
  input  logic [FP_W-1:0] mul_r_i
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned CntW   = $clog2(MUL_LAT + 3);
  localparam int unsigned Stages = MUL_LAT + 1;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               accept;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  tag_t               tag_q [Stages];
  tag_t               tag_in;
  logic [FP_W-1:0]    mul_x_q, mul_y_q;
  logic [FP_W-1:0]    sel_x, sel_y;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               res_valid_q;
  logic [IdW-1:0]     res_id_q;
  logic [FP_W-1:0]    res_data_q;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i (bus_io.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (~bus_io.hold & ~reset_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grants are only issued to valid lanes, so any grant is an accept.
  assign accept = |gnt;

  always_comb begin
    sel_x        = bus_io.req_x[gnt_idx*FP_W +: FP_W];
    sel_y        = bus_io.req_y[gnt_idx*FP_W +: FP_W];
    tag_in.valid = accept;
    tag_in.id    = accept ? TAG_ID_W'(gnt_idx) : '0;
    rr_ptr_d     = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdW'(1);
    cnt_d        = cnt_q + CntW'(accept) - CntW'(res_valid_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q    <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      for (int i = 0; i < Stages; i++) tag_q[i] <= '0;
    end else begin
      if (accept) begin
        mul_x_q  <= sel_x;
        mul_y_q  <= sel_y;
        rr_ptr_q <= rr_ptr_d;
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i < Stages; i++) tag_q[i] <= tag_q[i-1];
      cnt_q       <= cnt_d;
      res_valid_q <= tag_q[Stages-1].valid;
      res_id_q    <= tag_q[Stages-1].id[IdW-1:0];
      res_data_q  <= mul_r_i;
    end
  end

  assign bus_io.req_ready = gnt;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_id    = res_id_q;
  assign bus_io.res_data  = res_data_q;
  assign bus_io.busy      = (cnt_q != '0);
  assign mul_x_o          = mul_x_q;
  assign mul_y_o          = mul_y_q;

endmodule
